// File: rtl/gate_sequencer_if.sv
// Detector-slot bus and host result signals shared by gate_sequencer and its surroundings.
// Slot k occupies pins [12k+11:12k] and gates [6k+5:6k] of the packed detector buses.
interface gate_sequencer_if;
  localparam int unsigned NSLOT  = 4;
  localparam int unsigned PIN_W  = 12;
  localparam int unsigned GATE_W = 6;
  localparam int unsigned TYPE_W = 3;

  logic                      start;
  logic [NSLOT*PIN_W-1:0]    det_pins_out;
  logic [NSLOT*PIN_W-1:0]    det_pins_dir;
  logic [NSLOT-1:0]          det_done;
  logic [NSLOT-1:0]          det_found;
  logic [NSLOT*GATE_W-1:0]   det_gates;
  logic [NSLOT-1:0]          det_enable;
  logic [NSLOT-1:0]          det_rst;
  logic [PIN_W-1:0]          pins_out;
  logic [PIN_W-1:0]          pins_dir;
  logic                      busy;
  logic                      done;
  logic [TYPE_W-1:0]         gate_type;
  logic [GATE_W-1:0]         gate_mask;
  logic                      error;

  modport master (
    input  start, det_pins_out, det_pins_dir, det_done, det_found, det_gates,
    output det_enable, det_rst, pins_out, pins_dir, busy, done, gate_type, gate_mask, error
  );

  modport slave (
    output start, det_pins_out, det_pins_dir, det_done, det_found, det_gates,
    input  det_enable, det_rst, pins_out, pins_dir, busy, done, gate_type, gate_mask, error
  );
endinterface

// File: rtl/gate_sequencer.sv
// Runs the four gate detectors one after another (clear, run, evaluate) and reports the
// first slot that recognises the gate, or a timeout if the active slot never finishes.
module gate_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned NSLOT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  gate_sequencer_if.master bus
);

  localparam int unsigned SLOT_N  = 4;
  localparam int unsigned PIN_W   = 12;
  localparam int unsigned GATE_W  = 6;
  localparam int unsigned TYPE_W  = 3;
  localparam int unsigned SLOT_W  = 2;
  localparam int unsigned CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_EVAL,
    S_FINISH,
    S_FAIL
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SLOT_N-1:0]   det_enable_q, det_enable_d;
  logic [SLOT_N-1:0]   det_rst_q, det_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [TYPE_W-1:0]   gate_type_q, gate_type_d;
  logic [GATE_W-1:0]   gate_mask_q, gate_mask_d;

  logic [5:0]          pin_lsb;
  logic [4:0]          gate_lsb;
  logic                act_done;
  logic                act_found;
  logic [GATE_W-1:0]   act_gates;
  logic [PIN_W-1:0]    act_pins_out;
  logic [PIN_W-1:0]    act_pins_dir;
  logic                pins_window;

  function automatic logic [SLOT_N-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
    slot_onehot    = '0;
    slot_onehot[s] = 1'b1;
  endfunction

  // Pick out the active slot's fields from the packed detector buses.
  always_comb begin
    pin_lsb      = 6'(slot_q) * 6'(PIN_W);
    gate_lsb     = 5'(slot_q) * 5'(GATE_W);
    act_done     = bus.det_done[slot_q];
    act_found    = bus.det_found[slot_q];
    act_gates    = bus.det_gates[gate_lsb +: GATE_W];
    act_pins_out = bus.det_pins_out[pin_lsb +: PIN_W];
    act_pins_dir = bus.det_pins_dir[pin_lsb +: PIN_W];
  end

  // GPIO belongs to the active detector only while it runs or is evaluated.
  always_comb begin
    pins_window  = (state_q == S_RUN) || (state_q == S_EVAL);
    bus.pins_out = pins_window ? act_pins_out : '0;
    bus.pins_dir = pins_window ? act_pins_dir : '0;
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    error_d     = error_q;
    gate_type_d = gate_type_q;
    gate_mask_d = gate_mask_q;

    unique case (state_q)
      S_IDLE, S_FINISH, S_FAIL: begin
        if (bus.start) begin
          state_d     = S_CLEAR;
          slot_d      = '0;
          done_d      = 1'b0;
          error_d     = 1'b0;
          gate_type_d = '0;
          gate_mask_d = '0;
        end
      end

      S_CLEAR: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end

      // A finishing detector beats a timeout landing on the same cycle.
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (act_done) begin
          state_d = S_EVAL;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAIL;
          error_d = 1'b1;
          done_d  = 1'b1;
        end
      end

      S_EVAL: begin
        if (act_found) begin
          state_d     = S_FINISH;
          done_d      = 1'b1;
          gate_type_d = TYPE_W'(slot_q) + TYPE_W'(1);
          gate_mask_d = act_gates;
        end else if (slot_q == LAST_SLOT) begin
          state_d     = S_FINISH;
          done_d      = 1'b1;
          gate_type_d = '0;
          gate_mask_d = '0;
        end else begin
          state_d = S_CLEAR;
          slot_d  = slot_q + SLOT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Slot strobes are decoded from the next state so they register in step with it.
  always_comb begin
    det_enable_d = '0;
    det_rst_d    = '0;
    busy_d       = 1'b0;
    unique case (state_d)
      S_CLEAR: begin
        det_rst_d = slot_onehot(slot_d);
        busy_d    = 1'b1;
      end
      S_RUN, S_EVAL: begin
        det_enable_d = slot_onehot(slot_d);
        busy_d       = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      cnt_q        <= '0;
      det_enable_q <= '0;
      det_rst_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      gate_type_q  <= '0;
      gate_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      cnt_q        <= cnt_d;
      det_enable_q <= det_enable_d;
      det_rst_q    <= det_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      gate_type_q  <= gate_type_d;
      gate_mask_q  <= gate_mask_d;
    end
  end

  assign bus.det_enable = det_enable_q;
  assign bus.det_rst    = det_rst_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.gate_type  = gate_type_q;
  assign bus.gate_mask  = gate_mask_q;

  // A detector is never cleared and enabled at once, and at most one slot is ever live.
  a_enable_rst_exclusive: assert property (@(posedge clk) disable iff (rst)
    !((|det_enable_q) && (|det_rst_q)));
  a_enable_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(det_enable_q));
  a_busy_matches_state: assert property (@(posedge clk) disable iff (rst)
    busy_q == ((state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_EVAL)));

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer: behavioural detectors drive the slots, a per-pass
// expected trace is built from the sequencing rules and checked every cycle.
module tb_gate_sequencer;
  localparam int unsigned TO = 255;

  typedef struct packed {
    logic [3:0]  en;
    logic [3:0]  clr;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  gtype;
    logic [5:0]  gmask;
    logic [11:0] pdir;
    logic [11:0] pout;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_sequencer_if bus();

  gate_sequencer #(.TIMEOUT(TO), .NSLOT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          lat [4];
  logic        fnd [4];
  logic [5:0]  gts [4];
  logic [11:0] pdir [4];
  logic [11:0] pout [4];
  logic        noise;
  int          en_cnt [4];

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q [$];

  logic [3:0] en_seen;
  logic [3:0] prev_en;
  logic [3:0] prev_rst;
  logic [3:0] en_seq [$];
  logic       rst_ok;
  int         en1_cycles;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Detector model: done after lat[k] enabled cycles (lat<0 never); optional noise
  // raises done on every slot that is not currently enabled.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst || bus.det_rst[k]) en_cnt[k] <= 0;
      else if (bus.det_enable[k]) en_cnt[k] <= en_cnt[k] + 1;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bus.det_done[k]              = ((lat[k] >= 0) && (en_cnt[k] == lat[k])) ||
                                     (noise && !bus.det_enable[k]);
      bus.det_found[k]             = fnd[k];
      bus.det_gates[6*k +: 6]      = gts[k];
      bus.det_pins_out[12*k +: 12] = pout[k];
      bus.det_pins_dir[12*k +: 12] = pdir[k];
    end
  end

  // Expected per-cycle outputs of a whole pass from the sequencing rules.
  function automatic int push_final(input logic err, input logic [2:0] gt, input logic [5:0] gm);
    exp_t e = '0;
    e.done  = 1'b1;
    e.err   = err;
    e.gtype = gt;
    e.gmask = gm;
    repeat (3) exp_q.push_back(e);
    return 3;
  endfunction

  function automatic int build_trace();
    exp_t e;
    int   n = 0;
    int   run_len;
    bit   timed_out;
    for (int k = 0; k < 4; k++) begin
      e      = '0;
      e.clr  = 4'(1 << k);
      e.busy = 1'b1;
      exp_q.push_back(e);
      n++;
      timed_out = !((lat[k] >= 0) && (lat[k] < int'(TO)));
      run_len   = timed_out ? int'(TO) : lat[k] + 1;
      e      = '0;
      e.en   = 4'(1 << k);
      e.busy = 1'b1;
      e.pdir = pdir[k];
      e.pout = pout[k];
      for (int i = 0; i < run_len; i++) begin
        exp_q.push_back(e);
        n++;
      end
      if (timed_out) return n + push_final(1'b1, 3'd0, 6'd0);
      exp_q.push_back(e);
      n++;
      if (fnd[k]) return n + push_final(1'b0, 3'(k + 1), gts[k]);
    end
    return n + push_final(1'b0, 3'd0, 6'd0);
  endfunction

  // Single compare process: every cycle with an expectation pending.
  always @(negedge clk) begin : compare
    exp_t e;
    exp_t o;
    if (exp_q.size() != 0) begin
      e       = exp_q.pop_front();
      o.en    = bus.det_enable;
      o.clr   = bus.det_rst;
      o.busy  = bus.busy;
      o.done  = bus.done;
      o.err   = bus.error;
      o.gtype = bus.gate_type;
      o.gmask = bus.gate_mask;
      o.pdir  = bus.pins_dir;
      o.pout  = bus.pins_out;
      chk("cycle", 64'(o), 64'(e));
      chk("en_rst_excl", 64'((|bus.det_enable) && (|bus.det_rst)), 64'(0));
    end
  end

  // Records the enable order and whether each enable was preceded by its clear pulse.
  always @(negedge clk) begin
    if (bus.det_rst == 4'b0001) begin
      en_seen    = '0;
      en_seq.delete();
      en1_cycles = 0;
      rst_ok     = 1'b1;
    end
    if ((bus.det_enable != 4'b0000) && (bus.det_enable != prev_en)) begin
      en_seq.push_back(bus.det_enable);
      if (prev_rst != bus.det_enable) rst_ok = 1'b0;
    end
    en_seen    = en_seen | bus.det_enable;
    en1_cycles = en1_cycles + int'(bus.det_enable[1]);
    prev_en    = bus.det_enable;
    prev_rst   = bus.det_rst;
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 64'(exp_q.size()), 64'(0));
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic run_pass(input string name, input int want_len);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    n = build_trace();
    chk({name, "_len"}, 64'(n), 64'(want_len));
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain(name);
  endtask

  task automatic set_slots(input int l0, input int l1, input int l2, input int l3,
                           input logic [3:0] f, input logic [5:0] g);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    for (int k = 0; k < 4; k++) begin
      fnd[k] = f[k];
      gts[k] = g ^ 6'(k);
    end
  endtask

  task automatic push_zero(input int cnt);
    exp_t e = '0;
    repeat (cnt) exp_q.push_back(e);
  endtask

  initial begin
    logic [3:0] want_seq [4];
    want_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst       = 1'b1;
    bus.start = 1'b0;
    noise     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pdir[k] = (k == 2) ? 12'h555 : (12'h0A0 | 12'(k));
      pout[k] = 12'h300 + 12'(k * 17);
    end
    set_slots(-1, -1, -1, -1, 4'b0000, 6'd0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    push_zero(3);
    @(negedge clk);
    rst = 1'b0;
    wait_drain("reset");
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_pins_dir", 64'(bus.pins_dir), 64'(0));

    // Slot 0 matches immediately; later slots never enabled
    set_slots(12, 1, 1, 1, 4'b0001, 6'b111111);
    gts[0] = 6'b111111;
    run_pass("slot0_match", 18);
    chk("slot0_type", 64'(bus.gate_type), 64'(1));
    chk("slot0_mask", 64'(bus.gate_mask), 64'h3F);
    chk("slot0_done", 64'(bus.done), 64'(1));
    chk("slot0_en_seen", 64'(en_seen), 64'b0001);

    // Slot 3 matches after three misses; slot 2 drives pins_dir=555 while running
    set_slots(3, 5, 2, 7, 4'b1000, 6'd0);
    gts[3] = 6'b001111;
    run_pass("slot3_match", 32);
    chk("slot3_seq_len", 64'(en_seq.size()), 64'(4));
    for (int i = 0; i < 4 && i < en_seq.size(); i++)
      chk("slot3_seq", 64'(en_seq[i]), 64'(want_seq[i]));
    chk("slot3_rst_before_en", 64'(rst_ok), 64'(1));
    chk("slot3_type", 64'(bus.gate_type), 64'(4));
    chk("slot3_mask", 64'(bus.gate_mask), 64'b001111);
    chk("slot3_pins_dir_after", 64'(bus.pins_dir), 64'(0));

    // No slot matches; done on inactive slots must be ignored
    noise = 1'b1;
    set_slots(1, 1, 1, 1, 4'b0000, 6'h2A);
    run_pass("no_match", 19);
    noise = 1'b0;
    chk("no_match_done", 64'(bus.done), 64'(1));
    chk("no_match_type", 64'(bus.gate_type), 64'(0));
    chk("no_match_err", 64'(bus.error), 64'(0));

    // Slot 1 never finishes -> timeout after 255 RUN cycles
    set_slots(0, -1, 1, 1, 4'b1110, 6'h15);
    run_pass("timeout", 262);
    chk("timeout_en1_cycles", 64'(en1_cycles), 64'(255));
    chk("timeout_err", 64'(bus.error), 64'(1));
    chk("timeout_done", 64'(bus.done), 64'(1));
    chk("timeout_pins_dir", 64'(bus.pins_dir), 64'(0));

    // done on the last allowed cycle wins over the timeout
    set_slots(int'(TO) - 1, 1, 1, 1, 4'b0001, 6'h21);
    run_pass("edge_done", 260);
    chk("edge_done_err", 64'(bus.error), 64'(0));
    chk("edge_done_type", 64'(bus.gate_type), 64'(1));

    // done one cycle too late is a timeout
    set_slots(int'(TO), 1, 1, 1, 4'b0001, 6'h21);
    run_pass("edge_late", 259);
    chk("edge_late_err", 64'(bus.error), 64'(1));

    // start during RUN is ignored; rst together with start aborts the pass
    set_slots(-1, -1, -1, -1, 4'b0000, 6'd0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    void'(build_trace());
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", 64'(bus.busy), 64'(1));
    rst       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    push_zero(3);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    wait_drain("abort");
    chk("abort_pins_dir", 64'(bus.pins_dir), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_enable", 64'(bus.det_enable), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
